// File: rtl/sysbus_arbiter.sv
// Sysbus master-port arbiter: shares one bus master between the instruction
// fetch requester (id 0) and the data memory requester (id 1). One transaction
// is outstanding at a time; write beats are streamed straight from the owning
// requester and read beats are routed back to it.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // requester side
    input  logic [1:0]                    req,
    input  logic [1:0]                    we,
    input  logic [2*BUS_DATA_WIDTH-1:0]   addr,
    input  logic [7:0]                    rtype,
    input  logic [2*BUS_DATA_WIDTH-1:0]   wdata,
    output logic [1:0]                    gnt,
    output logic [1:0]                    wdata_take,
    output logic [BUS_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                    rvalid,
    output logic [1:0]                    done,
    // bus side
    output logic                          bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]     bus_req,
    output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
    input  logic                          bus_reqack,
    input  logic                          bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag,
    output logic                          bus_respack
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Tag field positions on the request/response tag
    localparam int TAG_READ_BIT = 12;

    logic [1:0]                state_reg;
    logic                      owner_reg;
    logic                      is_write_reg;
    logic [BUS_DATA_WIDTH-1:0] addr_reg;
    logic [BUS_TAG_WIDTH-1:0]  tag_reg;
    logic [CNT_W-1:0]          beat_cnt_reg;
    logic                      last_served_reg;
    logic                      reqcyc_reg;
    logic [BUS_DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]                rvalid_reg;
    logic [1:0]                done_reg;

    logic                      win_valid;
    logic                      win_id;
    logic [BUS_TAG_WIDTH-1:0]  tag_new;
    logic [BUS_DATA_WIDTH-1:0] owner_wdata;
    logic                      addr_ack;
    logic                      data_ack;
    logic                      resp_hit;
    logic                      last_beat;
    logic                      resptag_unused;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        win_valid = |req;
        win_id    = 1'b0;
        case (req)
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last_served_reg;
            default: win_id = 1'b0;
        endcase
    end

    // Request tag for the winner: read flag, type nibble, requester id.
    always_comb begin
        tag_new               = '0;
        tag_new[TAG_READ_BIT] = ~(win_id ? we[1] : we[0]);
        tag_new[11:8]         = win_id ? rtype[7:4] : rtype[3:0];
        tag_new[0]            = win_id;
    end

    // Handshake qualifiers for the current state
    assign addr_ack  = (state_reg == ST_ADDR)  && bus_reqack;
    assign data_ack  = (state_reg == ST_WDATA) && bus_reqack;
    assign resp_hit  = (state_reg == ST_RESP) && bus_respcyc &&
                       bus_resptag[TAG_READ_BIT] && (bus_resptag[0] == owner_reg);
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

    // Only the read flag and id bits of the response tag matter here.
    assign resptag_unused = ^bus_resptag;

    // Write data comes straight from the owner so a fresh beat can be taken
    // every cycle without a bubble.
    assign owner_wdata = owner_reg ? wdata[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                                   : wdata[BUS_DATA_WIDTH-1:0];

    // Bus request payload: address in ADDR, owner's beat in WDATA, else quiet.
    always_comb begin
        bus_req = '0;
        if (state_reg == ST_WDATA) begin
            bus_req = owner_wdata;
        end else if (state_reg == ST_ADDR) begin
            bus_req = addr_reg;
        end
    end

    assign bus_reqcyc  = reqcyc_reg;
    assign bus_reqtag  = reqcyc_reg ? tag_reg : '0;
    assign bus_respack = resp_hit;
    assign rdata       = rdata_reg;
    assign rvalid      = rvalid_reg;
    assign done        = done_reg;

    // Per-requester decode of the acceptance pulses
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt[gi]        = addr_ack && (owner_reg == 1'(gi));
        assign wdata_take[gi] = data_ack && (owner_reg == 1'(gi));
    end

    // Transaction FSM: arbitrate, address phase, write streaming or read collection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= 1'b0;
            is_write_reg    <= 1'b0;
            addr_reg        <= '0;
            tag_reg         <= '0;
            beat_cnt_reg    <= '0;
            last_served_reg <= 1'b1;
            reqcyc_reg      <= 1'b0;
            rdata_reg       <= '0;
            rvalid_reg      <= 2'b00;
            done_reg        <= 2'b00;
        end else begin
            rvalid_reg <= 2'b00;
            done_reg   <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        owner_reg    <= win_id;
                        is_write_reg <= win_id ? we[1] : we[0];
                        addr_reg     <= win_id ? addr[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                                               : addr[BUS_DATA_WIDTH-1:0];
                        tag_reg      <= tag_new;
                        beat_cnt_reg <= '0;
                        reqcyc_reg   <= 1'b1;
                        state_reg    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus_reqack) begin
                        last_served_reg <= owner_reg;
                        if (is_write_reg) begin
                            state_reg <= ST_WDATA;
                        end else begin
                            reqcyc_reg <= 1'b0;
                            state_reg  <= ST_RESP;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus_reqack) begin
                        if (last_beat) begin
                            beat_cnt_reg <= '0;
                            done_reg     <= owner_reg ? 2'b10 : 2'b01;
                            reqcyc_reg   <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_hit) begin
                        rdata_reg  <= bus_resp;
                        rvalid_reg <= owner_reg ? 2'b10 : 2'b01;
                        if (last_beat) begin
                            beat_cnt_reg <= '0;
                            done_reg     <= owner_reg ? 2'b10 : 2'b01;
                            state_reg    <= ST_IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    reqcyc_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: read/write transactions, stalls,
// round-robin ordering, mismatched response tags and mid-transaction reset.
module tb_sysbus_arbiter;

    localparam int W     = 64;
    localparam int T     = 13;
    localparam int BEATS = 8;

    logic           clk;
    logic           reset_n;
    logic [1:0]     req;
    logic [1:0]     we;
    logic [2*W-1:0] addr;
    logic [7:0]     rtype;
    logic [2*W-1:0] wdata;
    logic [1:0]     gnt;
    logic [1:0]     wdata_take;
    logic [W-1:0]   rdata;
    logic [1:0]     rvalid;
    logic [1:0]     done;
    logic           bus_reqcyc;
    logic [W-1:0]   bus_req;
    logic [T-1:0]   bus_reqtag;
    logic           bus_reqack;
    logic           bus_respcyc;
    logic [W-1:0]   bus_resp;
    logic [T-1:0]   bus_resptag;
    logic           bus_respack;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int   compared   = 0;
    int   mismatched = 0;
    int   gnt_cnt[2];
    int   done_cnt[2];
    int   take_cnt[2];
    logic exp_respack;

    sysbus_arbiter #(
        .BUS_DATA_WIDTH(W),
        .BUS_TAG_WIDTH (T),
        .BEATS         (BEATS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .rtype      (rtype),
        .wdata      (wdata),
        .gnt        (gnt),
        .wdata_take (wdata_take),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .done       (done),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard side: pops expected beats whenever the DUT emits one.
    task automatic monitor();
        exp_t e;
        if (bus_respcyc === 1'b1) chk("respack", 64'(bus_respack), 64'(exp_respack));
        if (rvalid !== 2'b00) begin
            if (rd_q.size() == 0) begin
                chk("rvalid_unexpected", 64'(rvalid), 64'd0);
            end else begin
                e = rd_q.pop_front();
                chk("rvalid", 64'(rvalid), 64'(oh(e.id)));
                chk("rdata", rdata, e.data);
                chk("rd_done", 64'(done), e.last ? 64'(oh(e.id)) : 64'd0);
            end
        end
        if (wdata_take !== 2'b00) begin
            if (wr_q.size() == 0) begin
                chk("take_unexpected", 64'(wdata_take), 64'd0);
            end else begin
                e = wr_q.pop_front();
                chk("wdata_take", 64'(wdata_take), 64'(oh(e.id)));
                chk("wr_beat", bus_req, e.data);
            end
        end
        for (int i = 0; i < 2; i++) begin
            gnt_cnt[i]  += int'(gnt[i]);
            done_cnt[i] += int'(done[i]);
            take_cnt[i] += int'(wdata_take[i]);
        end
    endtask

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        $display("check %s outputs", name);
        chk("zero_gnt",     64'(gnt),         64'd0);
        chk("zero_take",    64'(wdata_take),  64'd0);
        chk("zero_rdata",   rdata,            64'd0);
        chk("zero_rvalid",  64'(rvalid),      64'd0);
        chk("zero_done",    64'(done),        64'd0);
        chk("zero_reqcyc",  64'(bus_reqcyc),  64'd0);
        chk("zero_req",     bus_req,          64'd0);
        chk("zero_reqtag",  64'(bus_reqtag),  64'd0);
        chk("zero_respack", 64'(bus_respack), 64'd0);
    endtask

    task automatic wait_reqcyc();
        int n = 0;
        while (bus_reqcyc !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("reqcyc_wait", 64'(bus_reqcyc), 64'd1);
    endtask

    // Address phase: check request, hold off the ack for 'stall' cycles, then accept.
    task automatic start_txn(input logic [12:0] exp_tag, input logic [63:0] exp_addr,
                             input int stall, input logic [1:0] drop);
        wait_reqcyc();
        chk("addr_tag", 64'(bus_reqtag), 64'(exp_tag));
        chk("addr_req", bus_req, exp_addr);
        for (int s = 0; s < stall; s++) begin
            bus_reqack = 1'b0;
            cyc();
            chk("stall_tag",    64'(bus_reqtag), 64'(exp_tag));
            chk("stall_req",    bus_req,         exp_addr);
            chk("stall_reqcyc", 64'(bus_reqcyc), 64'd1);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(oh(exp_tag[0])));
        monitor();
        @(posedge clk);
        #1;
        bus_reqack = 1'b0;
        req = req & ~drop;
        $display("txn %s id=%0d addr=%0h tag=%0h granted",
                 exp_tag[12] ? "read" : "write", exp_tag[0], exp_addr, exp_tag);
    endtask

    // Response phase: feed beats, optionally slipping in one wrong-id beat.
    task automatic serve_read(input logic id, input logic [12:0] tag, input logic [63:0] base,
                              input int nbeats, input int bad_at);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            if (i == bad_at) begin
                bus_respcyc = 1'b1;
                bus_resp    = 64'hDEAD;
                bus_resptag = tag ^ 13'h0001;
                exp_respack = 1'b0;
                cyc();
            end
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(i);
            bus_resptag = tag;
            exp_respack = 1'b1;
            e.id   = id;
            e.data = base + 64'(i);
            e.last = (i == BEATS - 1);
            rd_q.push_back(e);
            cyc();
        end
        bus_respcyc = 1'b0;
        exp_respack = 1'b0;
        cyc();
        $display("txn read id=%0d beats=%0d served", id, nbeats);
    endtask

    initial begin
        exp_t e;
        logic [63:0] wbase;
        int d1;
        for (int i = 0; i < 2; i++) begin
            gnt_cnt[i] = 0; done_cnt[i] = 0; take_cnt[i] = 0;
        end
        req = 2'b00; we = 2'b00; addr = '0; rtype = 8'h00; wdata = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        exp_respack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Read from requester 0, 8 beats 0x10..0x17
        req = 2'b01; we = 2'b00; addr[63:0] = 64'h1000; rtype[3:0] = 4'b0011;
        start_txn(13'h1300, 64'h1000, 0, 2'b01);
        chk("rd_reqcyc_low", 64'(bus_reqcyc), 64'd0);
        serve_read(1'b0, 13'h1300, 64'h10, BEATS, -1);
        chk("t1_q_empty", 64'(rd_q.size()), 64'd0);
        chk("t1_done0",   64'(done_cnt[0]), 64'd1);
        chk("t1_gnt0",    64'(gnt_cnt[0]),  64'd1);

        // Write from requester 1 with address and mid-data stalls
        wbase = 64'hA0;
        req = 2'b10; we = 2'b10; addr[127:64] = 64'h2000; rtype[7:4] = 4'b0001;
        wdata[127:64] = wbase;
        start_txn(13'h0101, 64'h2000, 2, 2'b10);
        for (int k = 0; k < BEATS; k++) begin
            if (k == 4) begin
                bus_reqack = 1'b0;
                cyc();
                chk("wr_stall_req", bus_req, wbase + 64'd4);
                chk("wr_stall_tag", 64'(bus_reqtag), 64'h0101);
            end
            bus_reqack = 1'b1;
            e.id = 1'b1; e.data = wbase + 64'(k); e.last = 1'b0;
            wr_q.push_back(e);
            cyc();
            wdata[127:64] = wbase + 64'(k + 1);
        end
        bus_reqack = 1'b0;
        chk("wr_done",       64'(done),       64'h2);
        chk("wr_reqcyc_low", 64'(bus_reqcyc), 64'd0);
        cyc();
        $display("txn write id=1 beats=%0d served", take_cnt[1]);
        chk("t2_takes", 64'(take_cnt[1]), 64'd8);
        chk("t2_done1", 64'(done_cnt[1]), 64'd1);
        chk("t2_gnt1",  64'(gnt_cnt[1]),  64'd1);
        chk("t2_q_empty", 64'(wr_q.size()), 64'd0);

        // Round-robin from a fresh reset: 0, then 1, then 0 again
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        req = 2'b11; we = 2'b00; addr[63:0] = 64'h3000; addr[127:64] = 64'h4000; rtype = 8'h11;
        start_txn(13'h1100, 64'h3000, 0, 2'b01);
        serve_read(1'b0, 13'h1100, 64'h30, BEATS, -1);
        start_txn(13'h1101, 64'h4000, 0, 2'b10);
        serve_read(1'b1, 13'h1101, 64'h40, BEATS, -1);
        req = 2'b11;
        start_txn(13'h1100, 64'h3000, 0, 2'b01);
        // wrong-id beat injected after three good ones
        serve_read(1'b0, 13'h1100, 64'h50, BEATS, 3);
        chk("t4_done0", 64'(done_cnt[0]), 64'd3);

        // Requester 1 still pending; abort it with reset after 3 beats
        start_txn(13'h1101, 64'h4000, 0, 2'b10);
        serve_read(1'b1, 13'h1101, 64'h60, 3, -1);
        d1 = done_cnt[1];
        bus_respcyc = 1'b1; bus_resptag = 13'h1101; bus_resp = 64'h63;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus_respcyc = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("t5_q_empty", 64'(rd_q.size()), 64'd0);
        req = 2'b01; we = 2'b00; addr[63:0] = 64'h5000; rtype[3:0] = 4'b0011;
        start_txn(13'h1300, 64'h5000, 0, 2'b01);
        serve_read(1'b0, 13'h1300, 64'h70, BEATS, -1);
        chk("t5_no_done1", 64'(done_cnt[1]), 64'(d1));
        chk("t5_done0",    64'(done_cnt[0]), 64'd4);
        chk("t5_q_end",    64'(rd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between two requesters: requester 0 (instruction fetch) and requester 1 (data memory stage).
- Arbitrates between them, drives one bus transaction at a time and streams write data beats.
- Collects read response beats, acks them and routes them back to the requester that owns the transaction.
- Sits between the pipeline memory-facing stages and the top-level bus pins.

Parameters:
BUS_DATA_WIDTH, 64, bus data/address width
BUS_TAG_WIDTH, 13, bus tag width
BEATS, 8, data beats per transaction (one 512-bit line)

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
req  in  2  per-requester request; bit i = requester i
we  in  2  per-requester write (1) / read (0)
addr  in  2*BUS_DATA_WIDTH  per-requester address; requester i at [i*64 +: 64]
rtype  in  8  per-requester tag type nibble (0001 MEMORY, 0011 MMIO); [i*4 +: 4]
wdata  in  2*BUS_DATA_WIDTH  per-requester current write beat
gnt  out  2  one-cycle pulse when requester i's address phase is accepted
wdata_take  out  2  one-cycle pulse when the current wdata beat of requester i is consumed
rdata  out  BUS_DATA_WIDTH  read beat, shared by both requesters
rvalid  out  2  rdata valid for requester i
done  out  2  one-cycle pulse when requester i's transaction completes
bus_reqcyc  out  1  bus request cycle
bus_req  out  BUS_DATA_WIDTH  address, then write data
bus_reqtag  out  BUS_TAG_WIDTH  [12] 1=READ 0=WRITE; [11:8] rtype; [7:1] zero; [0] requester id
bus_reqack  in  1  bus accepts the current request beat
bus_respcyc  in  1  response beat valid
bus_resp  in  BUS_DATA_WIDTH  response data
bus_resptag  in  BUS_TAG_WIDTH  response tag
bus_respack  out  1  acknowledges the response beat

Behaviour:
- Reset (async, reset_n=0): state=IDLE, beat count=0, last-served=1 so requester 0 wins the first tie. All outputs are 0.
- Reset asserted mid-transaction aborts the transaction. No done pulse is issued.
- IDLE:
  - Arbitration is round-robin between asserted req bits.
  - On a tie, the requester not last served wins. A single requester wins immediately.
  - The winner's addr, we, rtype and id are latched.
  - Next state: ADDR.
- ADDR:
  - Registered outputs: bus_reqcyc=1, bus_req=latched addr, bus_reqtag as defined above.
  - Held stable until bus_reqack=1.
  - On ack: gnt[id] pulses and last-served=id.
  - Next state: WDATA if write, else RESP.
- WDATA:
  - bus_reqcyc=1, bus_req=wdata of the owner, bus_reqtag unchanged.
  - Each cycle with bus_reqack=1: wdata_take[id] pulses and the count increments.
  - The requester presents its next beat on the cycle after wdata_take.
  - After beat BEATS-1 is acked: done[id] pulses, count=0, bus_reqcyc=0, next state IDLE.
- RESP:
  - bus_reqcyc=0.
  - A beat is accepted when bus_respcyc=1 and bus_resptag[12]=1 and bus_resptag[0]=id.
  - Accepted beat, same cycle, combinational: bus_respack=1. Next cycle, registered: rdata=bus_resp, rvalid[id]=1 for one cycle.
  - A response beat with a mismatched tag gets bus_respack=0 and is ignored.
  - The accepted-beat count wraps at BEATS. On the last beat, done[id] pulses alongside the final rvalid, then next state IDLE.
- Requesters hold req, addr, we and rtype until gnt. They drop req on or after done.
  - A req still high in the IDLE cycle after done is treated as a new request.
- One outstanding transaction only. req is ignored outside IDLE.
- IDLE to ADDR costs 1 cycle. Minimum read latency from req to first rvalid is 3 cycles plus bus latency.

Test Plan:
- Read from requester 0, addr 0x1000, rtype 0011, bus acks at once and returns 8 beats 0x10..0x17 tagged 0x1300 -> bus_reqtag=0x1300, gnt[0] one pulse, rvalid[0] on 8 cycles with rdata 0x10..0x17, done[0] with the 8th beat, back to IDLE.
- Write from requester 1, addr 0x2000, bus_reqack stalled 2 cycles in ADDR and 1 cycle mid-data -> bus_req/bus_reqtag (0x0101) stable while stalled, exactly 8 wdata_take[1] pulses, done[1] after the 8th.
- Both req high from reset -> requester 0 served first, then 1. Both high again -> 0 is served next, because round-robin alternates.
- During RESP, inject a beat with bus_resptag[0] wrong -> bus_respack=0, no rvalid, beat count unchanged.
- reset_n pulsed low after 3 of 8 read beats -> all outputs 0 immediately, no done, next request starts a fresh ADDR with count=0.
